// File: rtl/dma_tx_cpl_rx.sv
// Completion receiver for the DMA TX read path: tracks per-tag descriptors, writes completion payload to RAM, returns finished tags.
// Optional macro DMA_TX_CPL_RX_STRICT_LEN_EN enforces payload length against the completion header.
module dma_tx_cpl_rx #(
    parameter int RAM_ADDR_WIDTH   = 18,
    parameter int REQUEST_LEN_BITS = 12,
    parameter int DATA_BITS        = 3,
    parameter int PCIE_TAG_BITS    = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   s_tcq_valid,
    output logic                                   s_tcq_ready,
    input  logic [RAM_ADDR_WIDTH-1:DATA_BITS]      s_tcq_laddr,
    input  logic [REQUEST_LEN_BITS-1:DATA_BITS]    s_tcq_length,
    input  logic [PCIE_TAG_BITS-1:0]               s_tcq_tag,
    input  logic                                   s_cplh_valid,
    output logic                                   s_cplh_ready,
    input  logic [PCIE_TAG_BITS-1:0]               s_cplh_tag,
    input  logic [REQUEST_LEN_BITS-1:DATA_BITS]    s_cplh_len,
    input  logic                                   s_cplh_final,
    input  logic                                   s_cplh_err,
    input  logic                                   s_cpld_valid,
    output logic                                   s_cpld_ready,
    input  logic [(8<<DATA_BITS)-1:0]              s_cpld_data,
    input  logic                                   s_cpld_last,
    output logic                                   m_ram_we,
    output logic [RAM_ADDR_WIDTH-1:DATA_BITS]      m_ram_addr,
    output logic [(8<<DATA_BITS)-1:0]              m_ram_data,
    output logic                                   m_tcq_cvalid,
    input  logic                                   m_tcq_cready,
    output logic [PCIE_TAG_BITS-1:0]               m_tcq_ctag,
    output logic                                   err_sticky
);

    localparam int AW = RAM_ADDR_WIDTH - DATA_BITS;
    localparam int LW = REQUEST_LEN_BITS - DATA_BITS;
    localparam int RW = LW + 1;
    localparam int NT = 1 << PCIE_TAG_BITS;

    typedef enum logic [1:0] {IDLE, DATA, UPD, TERM} state_t;

    state_t                   state;
    logic [AW-1:0]            tbl_addr [NT];
    logic [RW-1:0]            tbl_rem  [NT];
    logic [NT-1:0]            tag_vld;

    logic [PCIE_TAG_BITS-1:0] cur_tag;
    logic [AW-1:0]            cur_addr;
    logic [RW-1:0]            cur_rem;
    logic                     cur_final;
    logic                     cur_drop;

    logic tcq_acc, cplh_acc, cpld_acc, term_hs;
    logic excess, len_bad;

    assign tcq_acc  = s_tcq_valid & s_tcq_ready;
    assign cplh_acc = s_cplh_valid & s_cplh_ready;
    assign cpld_acc = s_cpld_valid & s_cpld_ready;
    assign term_hs  = m_tcq_cvalid & m_tcq_cready;

`ifdef DMA_TX_CPL_RX_STRICT_LEN_EN
    logic [LW-1:0] exp_len;
    logic [RW-1:0] beat_cnt;

    assign excess  = beat_cnt > RW'(exp_len);
    assign len_bad = s_cpld_last && (beat_cnt != RW'(exp_len));

    always_ff @(posedge clk) begin
        if (cplh_acc) begin
            exp_len  <= s_cplh_len;
            beat_cnt <= '0;
        end else if (cpld_acc && beat_cnt != '1) begin
            beat_cnt <= beat_cnt + RW'(1);
        end
    end
`else
    logic unused_len;
    assign unused_len = ^s_cplh_len;
    assign excess     = 1'b0;
    assign len_bad    = 1'b0;
`endif

    // Single table write port: UPD write-back owns it, descriptors are held off meanwhile
    always_ff @(posedge clk) begin
        if (state == UPD) begin
            tbl_addr[cur_tag] <= cur_addr;
            tbl_rem[cur_tag]  <= cur_rem;
        end else if (tcq_acc) begin
            tbl_addr[s_tcq_tag] <= s_tcq_laddr;
            tbl_rem[s_tcq_tag]  <= RW'(s_tcq_length) + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s_tcq_ready  <= 1'b0;
            s_cplh_ready <= 1'b0;
            s_cpld_ready <= 1'b0;
            m_ram_we     <= 1'b0;
            m_ram_addr   <= '0;
            m_ram_data   <= '0;
            m_tcq_cvalid <= 1'b0;
            m_tcq_ctag   <= '0;
            err_sticky   <= 1'b0;
            tag_vld      <= '0;
        end else begin
            m_ram_we <= 1'b0;
            // Clear before set so a same-cycle re-issue of the tag keeps it valid
            if (term_hs)
                tag_vld[m_tcq_ctag] <= 1'b0;
            if (tcq_acc) begin
                tag_vld[s_tcq_tag] <= 1'b1;
                if (tag_vld[s_tcq_tag])
                    err_sticky <= 1'b1;
            end

            case (state)
                IDLE: begin
                    s_tcq_ready  <= 1'b1;
                    s_cplh_ready <= 1'b1;
                    if (cplh_acc) begin
                        s_cplh_ready <= 1'b0;
                        cur_tag      <= s_cplh_tag;
                        cur_addr     <= tbl_addr[s_cplh_tag];
                        cur_rem      <= tbl_rem[s_cplh_tag];
                        cur_final    <= s_cplh_final;
                        cur_drop     <= ~tag_vld[s_cplh_tag];
                        if (s_cplh_err) begin
                            err_sticky   <= 1'b1;
                            m_tcq_cvalid <= 1'b1;
                            m_tcq_ctag   <= s_cplh_tag;
                            state        <= TERM;
                        end else begin
                            if (!tag_vld[s_cplh_tag])
                                err_sticky <= 1'b1;
                            s_cpld_ready <= 1'b1;
                            state        <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (cpld_acc) begin
                        if (!cur_drop && !excess) begin
                            if (cur_rem == '0) begin
                                err_sticky <= 1'b1;
                            end else begin
                                m_ram_we   <= 1'b1;
                                m_ram_addr <= cur_addr;
                                m_ram_data <= s_cpld_data;
                                cur_addr   <= cur_addr + AW'(1);
                                cur_rem    <= cur_rem - RW'(1);
                            end
                        end
                        if (excess || len_bad)
                            err_sticky <= 1'b1;
                        if (s_cpld_last) begin
                            s_cpld_ready <= 1'b0;
                            if (cur_drop) begin
                                s_cplh_ready <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                s_tcq_ready <= 1'b0;
                                state       <= UPD;
                            end
                        end
                    end
                end
                UPD: begin
                    s_tcq_ready <= 1'b1;
                    if (cur_final || cur_rem == '0) begin
                        m_tcq_cvalid <= 1'b1;
                        m_tcq_ctag   <= cur_tag;
                        state        <= TERM;
                    end else begin
                        s_cplh_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                TERM: begin
                    if (m_tcq_cready) begin
                        m_tcq_cvalid <= 1'b0;
                        s_cplh_ready <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_tx_cpl_rx.sv
// Scoreboard bench for dma_tx_cpl_rx: random/directed descriptors and completions against a per-tag reference model.
module tb_dma_tx_cpl_rx;

    localparam int RAW = 18;
    localparam int RLB = 12;
    localparam int DB  = 3;
    localparam int TB  = 4;
    localparam int AW  = RAW - DB;
    localparam int DW  = 8 << DB;
    localparam int NT  = 1 << TB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic               s_tcq_valid, s_tcq_ready;
    logic [RAW-1:DB]    s_tcq_laddr;
    logic [RLB-1:DB]    s_tcq_length;
    logic [TB-1:0]      s_tcq_tag;
    logic               s_cplh_valid, s_cplh_ready;
    logic [TB-1:0]      s_cplh_tag;
    logic [RLB-1:DB]    s_cplh_len;
    logic               s_cplh_final, s_cplh_err;
    logic               s_cpld_valid, s_cpld_ready;
    logic [DW-1:0]      s_cpld_data;
    logic               s_cpld_last;
    logic               m_ram_we;
    logic [RAW-1:DB]    m_ram_addr;
    logic [DW-1:0]      m_ram_data;
    logic               m_tcq_cvalid, m_tcq_cready;
    logic [TB-1:0]      m_tcq_ctag;
    logic               err_sticky;

    dma_tx_cpl_rx #(
        .RAM_ADDR_WIDTH(RAW), .REQUEST_LEN_BITS(RLB), .DATA_BITS(DB), .PCIE_TAG_BITS(TB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tcq_valid(s_tcq_valid), .s_tcq_ready(s_tcq_ready), .s_tcq_laddr(s_tcq_laddr),
        .s_tcq_length(s_tcq_length), .s_tcq_tag(s_tcq_tag),
        .s_cplh_valid(s_cplh_valid), .s_cplh_ready(s_cplh_ready), .s_cplh_tag(s_cplh_tag),
        .s_cplh_len(s_cplh_len), .s_cplh_final(s_cplh_final), .s_cplh_err(s_cplh_err),
        .s_cpld_valid(s_cpld_valid), .s_cpld_ready(s_cpld_ready), .s_cpld_data(s_cpld_data),
        .s_cpld_last(s_cpld_last),
        .m_ram_we(m_ram_we), .m_ram_addr(m_ram_addr), .m_ram_data(m_ram_data),
        .m_tcq_cvalid(m_tcq_cvalid), .m_tcq_cready(m_tcq_cready), .m_tcq_ctag(m_tcq_ctag),
        .err_sticky(err_sticky)
    );

    int checks = 0;
    int errors = 0;
    int gap_max = 0;
    bit hold_cready = 1'b0;

    // Scoreboard queues
    logic [AW-1:0] q_addr[$];
    logic [DW-1:0] q_data[$];
    logic [TB-1:0] q_term[$];

    // Reference model: per-tag next address, words outstanding, issued flag
    bit            mv [NT];
    logic [AW-1:0] ma [NT];
    int            mr [NT];
    bit            exp_err;
    int            c_tag, c_len;
    bit            c_drop, c_final;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event required one within bound", name);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) mv[i] = 1'b0;
        exp_err = 1'b0;
        q_addr.delete();
        q_data.delete();
        q_term.delete();
    endfunction

    function automatic void model_desc(input int tag, input int laddr, input int len);
        if (mv[tag]) exp_err = 1'b1;
        mv[tag] = 1'b1;
        ma[tag] = AW'(laddr);
        mr[tag] = len + 1;
    endfunction

    function automatic void model_hdr(input int tag, input int len, input bit fin, input bit err);
        c_tag = tag; c_len = len; c_final = fin;
        c_drop = !mv[tag];
        if (err) begin
            exp_err = 1'b1;
            q_term.push_back(TB'(tag));
            mv[tag] = 1'b0;
        end else if (c_drop) begin
            exp_err = 1'b1;
        end
    endfunction

    function automatic void model_beat(input int idx, input logic [DW-1:0] d);
        if (c_drop) return;
`ifdef DMA_TX_CPL_RX_STRICT_LEN_EN
        if (idx > c_len) begin
            exp_err = 1'b1;
            return;
        end
`endif
        if (mr[c_tag] == 0) begin
            exp_err = 1'b1;
            return;
        end
        q_addr.push_back(ma[c_tag]);
        q_data.push_back(d);
        ma[c_tag] = ma[c_tag] + AW'(1);
        mr[c_tag] = mr[c_tag] - 1;
    endfunction

    function automatic void model_end(input int n);
`ifdef DMA_TX_CPL_RX_STRICT_LEN_EN
        if (n != c_len + 1) exp_err = 1'b1;
`endif
        if (!c_drop && (c_final || mr[c_tag] == 0)) begin
            q_term.push_back(TB'(c_tag));
            mv[c_tag] = 1'b0;
        end
    endfunction

    // Termination ready: random unless the bench is holding it off
    initial begin
        m_tcq_cready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_tcq_cready = hold_cready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops expectations whenever the DUT presents a RAM write or a termination
    always @(negedge clk) begin
        if (m_ram_we === 1'b1) begin
            if (q_addr.size() == 0) begin
                checks++; errors++;
                $display("FAIL ram_write: got write addr %0h required none", m_ram_addr);
            end else begin
                chk("ram_addr", 64'(m_ram_addr), 64'(q_addr.pop_front()));
                chk("ram_data", m_ram_data, q_data.pop_front());
            end
        end
        if (m_tcq_cvalid === 1'b1 && m_tcq_cready === 1'b1) begin
            if (q_term.size() == 0) begin
                checks++; errors++;
                $display("FAIL term: got tag %0d required none", m_tcq_ctag);
            end else begin
                chk("term_tag", 64'(m_tcq_ctag), 64'(q_term.pop_front()));
            end
        end
    end

    task automatic drive_desc(input int tag, input int laddr, input int len);
        bit ok = 1'b0;
        model_desc(tag, laddr, len);
        s_tcq_valid = 1'b1; s_tcq_tag = TB'(tag); s_tcq_laddr = AW'(laddr); s_tcq_length = (RLB-DB)'(len);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (s_tcq_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        s_tcq_valid = 1'b0;
        if (!ok) fail_now("tcq_handshake");
    endtask

    task automatic drive_hdr(input int tag, input int len, input bit fin, input bit err);
        bit ok = 1'b0;
        model_hdr(tag, len, fin, err);
        s_cplh_valid = 1'b1; s_cplh_tag = TB'(tag); s_cplh_len = (RLB-DB)'(len);
        s_cplh_final = fin; s_cplh_err = err;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (s_cplh_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        s_cplh_valid = 1'b0;
        if (!ok) fail_now("cplh_handshake");
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input bit last);
        bit ok = 1'b0;
        repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        s_cpld_valid = 1'b1; s_cpld_data = d; s_cpld_last = last;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (s_cpld_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        s_cpld_valid = 1'b0; s_cpld_last = 1'b0;
        if (!ok) fail_now("cpld_handshake");
    endtask

    task automatic send_cpl(input int tag, input int n, input bit fin, input bit err, input int lenf);
        logic [DW-1:0] d;
        drive_hdr(tag, (lenf < 0) ? n - 1 : lenf, fin, err);
        if (!err) begin
            for (int i = 0; i < n; i++) begin
                d = {$urandom, $urandom};
                model_beat(i, d);
                drive_beat(d, i == n - 1);
            end
            model_end(n);
        end
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (q_addr.size() == 0 && q_term.size() == 0) ok = 1'b1;
        end
        if (!ok) fail_now({name, "_drain"});
        repeat (4) @(negedge clk);
        chk({name, "_err_sticky"}, 64'(err_sticky), 64'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_tcq_ready"},  64'(s_tcq_ready),  0);
        chk({name, "_cplh_ready"}, 64'(s_cplh_ready), 0);
        chk({name, "_cpld_ready"}, 64'(s_cpld_ready), 0);
        chk({name, "_ram_we"},     64'(m_ram_we),     0);
        chk({name, "_ram_addr"},   64'(m_ram_addr),   0);
        chk({name, "_ram_data"},   m_ram_data,        0);
        chk({name, "_cvalid"},     64'(m_tcq_cvalid), 0);
        chk({name, "_ctag"},       64'(m_tcq_ctag),   0);
        chk({name, "_err"},        64'(err_sticky),   0);
    endtask

    task automatic apply_reset(input string name);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs(name);
        model_reset();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] d;
        int t, len, left, n;
        bit fin;
        s_tcq_valid = 0; s_tcq_laddr = '0; s_tcq_length = '0; s_tcq_tag = '0;
        s_cplh_valid = 0; s_cplh_tag = '0; s_cplh_len = '0; s_cplh_final = 0; s_cplh_err = 0;
        s_cpld_valid = 0; s_cpld_data = '0; s_cpld_last = 0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("tcq_ready_after_reset", 64'(s_tcq_ready), 1);

        // Single completion, back-to-back beats, termination latency
        gap_max = 0;
        drive_desc(3, 'h100, 15);
        drive_hdr(3, 15, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom};
            model_beat(i, d);
            drive_beat(d, i == 15);
        end
        model_end(16);
        chk("cvalid_in_upd", 64'(m_tcq_cvalid), 0);
        chk("tcq_ready_in_upd", 64'(s_tcq_ready), 0);
        @(posedge clk); #1;
        chk("cvalid_after_2", 64'(m_tcq_cvalid), 1);
        chk("ctag_after_2", 64'(m_tcq_ctag), 3);
        drain("single");

        // Split read
        gap_max = 2;
        drive_desc(5, 'h200, 31);
        send_cpl(5, 16, 1'b0, 1'b0, -1);
        drain("split_a");
        send_cpl(5, 16, 1'b1, 1'b0, -1);
        drain("split_b");

        // Interleaved tags
        drive_desc(1, 'h400, 15);
        drive_desc(2, 'h800, 15);
        send_cpl(1, 8, 1'b0, 1'b0, -1);
        send_cpl(2, 8, 1'b0, 1'b0, -1);
        send_cpl(1, 8, 1'b1, 1'b0, -1);
        send_cpl(2, 8, 1'b1, 1'b0, -1);
        drain("interleave");

        // Address wrap and termination on exhausted count without final
        drive_desc(10, 'h7FFE, 3);
        send_cpl(10, 4, 1'b1, 1'b0, -1);
        drain("wrap");
        drive_desc(11, 'h50, 7);
        send_cpl(11, 8, 1'b0, 1'b0, -1);
        drain("exhaust");

        // Termination backpressure
        hold_cready = 1'b1;
        drive_desc(4, 'h300, 3);
        send_cpl(4, 4, 1'b1, 1'b0, -1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (m_tcq_cvalid) seen = 1'b1;
            end
            if (!seen) fail_now("bp_cvalid");
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_cvalid", 64'(m_tcq_cvalid), 1);
            chk("bp_ctag", 64'(m_tcq_ctag), 4);
            chk("bp_cplh_ready", 64'(s_cplh_ready), 0);
        end
        hold_cready = 1'b0;
        @(posedge clk); #1;
        drain("backpressure");

        // Randomized reads split into random completions
        for (int k = 0; k < 25; k++) begin
            gap_max = $urandom_range(0, 3);
            t = $urandom_range(0, NT - 1);
            len = $urandom_range(0, 40);
            drive_desc(t, $urandom_range(0, (1 << AW) - 1), len);
            left = len + 1;
            while (left > 0) begin
                n = $urandom_range(1, (left < 12) ? left : 12);
                fin = (n == left) ? 1'($urandom_range(0, 1)) : 1'b0;
                send_cpl(t, n, fin, 1'b0, -1);
                left -= n;
            end
            drain("random");
        end

        // Error completion, unissued tag, recycled tag
        drive_desc(7, 'h900, 3);
        drive_hdr(7, 0, 1'b0, 1'b1);
        chk("errhdr_cvalid", 64'(m_tcq_cvalid), 1);
        chk("errhdr_ctag", 64'(m_tcq_ctag), 7);
        drain("err_hdr");
        send_cpl(9, 5, 1'b1, 1'b0, -1);
        drain("unissued");
        send_cpl(3, 2, 1'b1, 1'b0, -1);
        drain("recycled");

        // Duplicate descriptor overwrites the entry
        apply_reset("rst_a");
        drive_desc(6, 'h10, 3);
        drive_desc(6, 'h20, 1);
        send_cpl(6, 2, 1'b1, 1'b0, -1);
        drain("dup_desc");

        // Remaining count never underflows
        apply_reset("rst_b");
        drive_desc(12, 'h40, 1);
        send_cpl(12, 4, 1'b0, 1'b0, -1);
        drain("underflow");

        // Header length vs payload length (only enforced in the strict build)
        apply_reset("rst_c");
        drive_desc(8, 'hA0, 7);
        send_cpl(8, 6, 1'b1, 1'b0, 7);
        drain("len_early");
        apply_reset("rst_d");
        drive_desc(13, 'hB0, 7);
        send_cpl(13, 4, 1'b1, 1'b0, 1);
        drain("len_late");

        // Reset mid-payload
        apply_reset("rst_e");
        drive_desc(14, 'hC0, 15);
        drive_hdr(14, 15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = {$urandom, $urandom};
            model_beat(i, d);
            drive_beat(d, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        model_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        send_cpl(14, 2, 1'b1, 1'b0, -1);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
